dp_sequencer: RTL



---
 rtl/dp_pkg.sv | 16 +
 rtl/dp_seq_fifo.sv | 37 +++
 rtl/dp_sequencer.sv | 73 +++++++
 3 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared instruction fields, NOP, flag index, sequencer states and decode helper
package dp_pkg;
  localparam int OPC_LSB = 12;
  localparam int SRCA_LSB = 8;
  localparam int EXT_LSB = 4;
  localparam int DST_LSB = 0;
  localparam int FLD_W = 4;
  localparam logic [15:0] NOP = 16'h0000;
  localparam int FLAG_CARRY = 3;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] EXT_ADD = 4'h5;
  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;
  function automatic logic [15:0] reg_en_decode(input logic [15:0] w);
    return (w == NOP) ? 16'h0000 : 16'h0001 << w[DST_LSB +: FLD_W];
  endfunction
endpackage

// File: rtl/dp_seq_fifo.sv
// dp_seq_fifo: synchronous power-of-two FIFO, no pass-through from push to pop
module dp_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: queued datapath instruction issue with decode, flag capture and retire count; DP_SEQ_CARRY_CHAIN_EN enables carry forwarding
module dp_sequencer
  import dp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             run_en,
  output logic [15:0]      dp_instr,
  output logic [15:0]      dp_reg_en,
  output logic             dp_cin,
  input  logic [4:0]       dp_flags,
  output logic [4:0]       flags_q,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);
  state_t state, state_n;
  logic push, pop, full, empty, ex_valid, retire;
  logic [15:0] head;
  logic [$clog2(DEPTH):0] count;
  dp_seq_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(instr_in),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign instr_ready = !full;
  assign push = instr_valid && !full;
  assign retire = ex_valid && dp_instr != NOP;
  assign busy = count != '0 || ex_valid;
  always_comb begin
    pop = state == ISSUE && run_en && !empty;
    state_n = state == IDLE  ? (push ? (run_en ? ISSUE : STALL) : IDLE)
            : state == ISSUE ? (!run_en ? STALL : (empty && !push) ? IDLE : ISSUE)
            : run_en ? ISSUE : STALL;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // execute slot is refilled or cleared every edge, so stalls and idles never re-write a register
  always_ff @(posedge clk)
    if (reset) begin
      ex_valid <= 1'b0;
      dp_instr <= NOP;
      dp_reg_en <= '0;
      flags_q <= '0;
      retired <= '0;
    end else begin
      ex_valid <= pop;
      dp_instr <= pop ? head : NOP;
      dp_reg_en <= pop ? reg_en_decode(head) : '0;
      if (retire) begin
        flags_q <= dp_flags;
        retired <= retired + CNT_W'(1);
      end
    end
`ifdef DP_SEQ_CARRY_CHAIN_EN
  logic carry_q;
  always_ff @(posedge clk)
    if (reset) begin
      carry_q <= 1'b0;
      dp_cin <= 1'b0;
    end else begin
      if (retire) carry_q <= dp_flags[FLAG_CARRY];
      dp_cin <= pop && (retire ? dp_flags[FLAG_CARRY] : carry_q);
    end
`else
  assign dp_cin = 1'b0;
`endif
endmodule
